// File: rtl/dcp_pkg.sv
// Shared constants, types and helpers for the Decoupled dispatch unit.
// Pure declarations: no logic, no latency.
package dcp_pkg;

    // Broadcast code is all-ones of the Dst field; users slice it to their AW.
    localparam logic [31:0] DCP_BCAST_DST = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        BCAST = 1'b1
    } disp_state_e;

    function automatic logic dst_legal(input logic [31:0] dst, input int unsigned snum);
        return dst < snum;
    endfunction

endpackage

// File: rtl/dcp_bcast_tracker.sv
// Broadcast sequencer: offers the head beat to every port not yet served and pops once all have taken it.
// Combinational offer/pop from registered sentMask; ports may accept in any cycle order.
module dcp_bcast_tracker
    import dcp_pkg::*;
#(
    parameter int unsigned SNUM = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            bcast_vld,
    input  logic [SNUM-1:0] port_rdy,
    output logic [SNUM-1:0] port_vld,
    output logic            pop
);
    disp_state_e     state_q;
    disp_state_e     state_d;
    logic [SNUM-1:0] sent_q;
    logic [SNUM-1:0] sent_d;
    logic [SNUM-1:0] accepting;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            sent_q  <= sent_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sent_d   = sent_q;
        port_vld = '0;
        pop      = 1'b0;
        case (state_q)
            IDLE:    if (bcast_vld) port_vld = {SNUM{1'b1}};
            BCAST:   port_vld = ~sent_q;
            default: ;
        endcase
        accepting = port_vld & port_rdy;
        if (port_vld != '0) begin
            if ((sent_q | accepting) == {SNUM{1'b1}}) begin
                pop     = 1'b1;
                sent_d  = '0;
                state_d = IDLE;
            end else begin
                sent_d  = sent_q | accepting;
                state_d = BCAST;
            end
        end
    end

endmodule

// File: rtl/gnrl_buf.sv
// Two-entry valid/ready buffer, output registered, 1 cycle from din to dout, full rate.
// CUT_RDY=1: din_rdy depends only on local state; din_rdy held low during and one cycle after reset.
module gnrl_buf #(
    parameter int unsigned DW      = 8,
    parameter bit          CUT_RDY = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din_vld,
    output logic          din_rdy,
    input  logic [DW-1:0] din_dat,
    output logic          dout_vld,
    input  logic          dout_rdy,
    output logic [DW-1:0] dout_dat
);
    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    cnt;
    logic          rdy_en;
    logic          push;
    logic          pop;

    assign dout_vld = (cnt != 2'd0);
    assign dout_dat = mem[rd_ptr];
    assign din_rdy  = rdy_en && ((cnt != 2'd2) || (!CUT_RDY && dout_rdy));
    assign push     = din_vld && din_rdy;
    assign pop      = dout_vld && dout_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

    // Storage needs no reset: cnt gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din_dat;
    end

endmodule

// File: rtl/dcp_dispatch_unit.sv
// One-to-many Decoupled dispatcher steering each beat by Dst; out-of-range Dst dropped and counted.
// 2-cycle latency, head-of-line blocking on busy port; DCP_DISPATCH_BCAST_EN adds all-ones broadcast.
module dcp_dispatch_unit
    import dcp_pkg::*;
#(
    parameter int unsigned DW   = 16,
    parameter int unsigned AW   = 2,
    parameter int unsigned SNUM = 4,
    parameter int unsigned CW   = 16
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
    input  logic                     iDcpIn_vld,
    output logic                     iDcpIn_rdy,
    input  logic [AW-1:0]            iDcpIn_dst,
    input  logic [DW-1:0]            iDcpIn_pld,
    output logic [SNUM-1:0]          oDcpOut_vld,
    input  logic [SNUM-1:0]          oDcpOut_rdy,
    output logic [SNUM-1:0][AW-1:0]  oDcpOut_dst,
    output logic [SNUM-1:0][DW-1:0]  oDcpOut_pld,
    output logic [CW-1:0]            oDropCnt
);
    localparam int unsigned BW = AW + DW;

    if (SNUM < 2 || SNUM > (1 << AW)) begin : g_bad_cfg
        $error("dcp_dispatch_unit: SNUM must be in [2, 2**AW]");
    end

    logic            head_vld;
    logic            head_pop;
    logic [BW-1:0]   head_dat;
    logic [AW-1:0]   head_dst;
    logic            head_legal;
    logic            head_bcast;
    logic            drop;
    logic [SNUM-1:0] uni_vld;
    logic [SNUM-1:0] bc_vld;
    logic            bc_pop;
    logic [SNUM-1:0] ob_vld;
    logic [SNUM-1:0] ob_rdy;

    gnrl_buf #(.DW(BW), .CUT_RDY(1'b1)) u_inbuf (
        .clk      (iClk),
        .rst_n    (iRst_n),
        .din_vld  (iDcpIn_vld),
        .din_rdy  (iDcpIn_rdy),
        .din_dat  ({iDcpIn_dst, iDcpIn_pld}),
        .dout_vld (head_vld),
        .dout_rdy (head_pop),
        .dout_dat (head_dat)
    );

    assign head_dst   = head_dat[BW-1:DW];
    assign head_legal = dst_legal(32'(head_dst), SNUM);

`ifdef DCP_DISPATCH_BCAST_EN
    localparam logic [AW-1:0] BCAST_DST = DCP_BCAST_DST[AW-1:0];

    // Broadcast takes precedence even when all-ones is also a real port index.
    assign head_bcast = head_vld && (head_dst == BCAST_DST);

    dcp_bcast_tracker #(.SNUM(SNUM)) u_bcast (
        .clk       (iClk),
        .rst_n     (iRst_n),
        .bcast_vld (head_bcast),
        .port_rdy  (ob_rdy),
        .port_vld  (bc_vld),
        .pop       (bc_pop)
    );
`else
    assign head_bcast = 1'b0;
    assign bc_vld     = '0;
    assign bc_pop     = 1'b0;
`endif

    always_comb begin
        uni_vld = '0;
        for (int k = 0; k < SNUM; k++) begin
            uni_vld[k] = head_vld && head_legal && (head_dst == AW'(k));
        end
        ob_vld   = head_bcast ? bc_vld : uni_vld;
        drop     = head_vld && !head_bcast && !head_legal;
        head_pop = head_bcast ? bc_pop : (drop || (|(uni_vld & ob_rdy)));
    end

    for (genvar k = 0; k < SNUM; k++) begin : g_ob
        logic [BW-1:0] ob_dat;

        gnrl_buf #(.DW(BW), .CUT_RDY(1'b1)) u_outbuf (
            .clk      (iClk),
            .rst_n    (iRst_n),
            .din_vld  (ob_vld[k]),
            .din_rdy  (ob_rdy[k]),
            .din_dat  (head_dat),
            .dout_vld (oDcpOut_vld[k]),
            .dout_rdy (oDcpOut_rdy[k]),
            .dout_dat (ob_dat)
        );

        assign oDcpOut_dst[k] = ob_dat[BW-1:DW];
        assign oDcpOut_pld[k] = ob_dat[DW-1:0];
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oDropCnt <= '0;
        end else if (drop && (oDropCnt != {CW{1'b1}})) begin
            oDropCnt <= oDropCnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_dcp_dispatch_unit.sv
// Bench: three dispatchers (SNUM=4/CW=16, SNUM=3/CW=16, SNUM=3/CW=2) against a queue-per-port scoreboard.
module tb_dcp_dispatch_unit;
`ifdef DCP_DISPATCH_BCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    typedef struct {
        logic [1:0]  dst;
        logic [15:0] pld;
        int          cyc;
    } beat_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    logic             a_ivld, a_irdy;
    logic [1:0]       a_idst;
    logic [15:0]      a_ipld;
    logic [3:0]       a_ovld, a_ordy;
    logic [3:0][1:0]  a_odst;
    logic [3:0][15:0] a_opld;
    logic [15:0]      a_cnt;

    logic             b_ivld, b_irdy, c_irdy;
    logic [1:0]       b_idst;
    logic [15:0]      b_ipld;
    logic [2:0]       b_ordy, b_ovld, c_ovld;
    logic [2:0][1:0]  b_odst, c_odst;
    logic [2:0][15:0] b_opld, c_opld;
    logic [15:0]      b_cnt;
    logic [1:0]       c_cnt;

    dcp_dispatch_unit #(.DW(16), .AW(2), .SNUM(4), .CW(16)) u_dut_a (
        .iClk(clk), .iRst_n(rst_n),
        .iDcpIn_vld(a_ivld), .iDcpIn_rdy(a_irdy), .iDcpIn_dst(a_idst), .iDcpIn_pld(a_ipld),
        .oDcpOut_vld(a_ovld), .oDcpOut_rdy(a_ordy), .oDcpOut_dst(a_odst), .oDcpOut_pld(a_opld),
        .oDropCnt(a_cnt));

    dcp_dispatch_unit #(.DW(16), .AW(2), .SNUM(3), .CW(16)) u_dut_b (
        .iClk(clk), .iRst_n(rst_n),
        .iDcpIn_vld(b_ivld), .iDcpIn_rdy(b_irdy), .iDcpIn_dst(b_idst), .iDcpIn_pld(b_ipld),
        .oDcpOut_vld(b_ovld), .oDcpOut_rdy(b_ordy), .oDcpOut_dst(b_odst), .oDcpOut_pld(b_opld),
        .oDropCnt(b_cnt));

    dcp_dispatch_unit #(.DW(16), .AW(2), .SNUM(3), .CW(2)) u_dut_c (
        .iClk(clk), .iRst_n(rst_n),
        .iDcpIn_vld(b_ivld), .iDcpIn_rdy(c_irdy), .iDcpIn_dst(b_idst), .iDcpIn_pld(b_ipld),
        .oDcpOut_vld(c_ovld), .oDcpOut_rdy(b_ordy), .oDcpOut_dst(c_odst), .oDcpOut_pld(c_opld),
        .oDropCnt(c_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Uniform view of the three instances for the scoreboard.
    logic        g_ivld [3];
    logic        g_irdy [3];
    logic [1:0]  g_idst [3];
    logic [15:0] g_ipld [3];
    logic [3:0]  g_ovld [3];
    logic [3:0]  g_ordy [3];
    logic [1:0]  g_odst [3][4];
    logic [15:0] g_opld [3][4];
    logic [15:0] g_cnt  [3];

    always_comb begin
        g_ivld[0] = a_ivld; g_irdy[0] = a_irdy; g_idst[0] = a_idst; g_ipld[0] = a_ipld;
        g_ivld[1] = b_ivld; g_irdy[1] = b_irdy; g_idst[1] = b_idst; g_ipld[1] = b_ipld;
        g_ivld[2] = b_ivld; g_irdy[2] = c_irdy; g_idst[2] = b_idst; g_ipld[2] = b_ipld;
        g_ovld[0] = a_ovld; g_ovld[1] = {1'b0, b_ovld}; g_ovld[2] = {1'b0, c_ovld};
        g_ordy[0] = a_ordy; g_ordy[1] = {1'b0, b_ordy}; g_ordy[2] = {1'b0, b_ordy};
        g_cnt[0]  = a_cnt;  g_cnt[1]  = b_cnt;          g_cnt[2]  = {14'd0, c_cnt};
        for (int k = 0; k < 4; k++) begin
            g_odst[0][k] = a_odst[k];
            g_opld[0][k] = a_opld[k];
            g_odst[1][k] = (k < 3) ? b_odst[k % 3] : 2'd0;
            g_opld[1][k] = (k < 3) ? b_opld[k % 3] : 16'd0;
            g_odst[2][k] = (k < 3) ? c_odst[k % 3] : 2'd0;
            g_opld[2][k] = (k < 3) ? c_opld[k % 3] : 16'd0;
        end
    end

    // Scoreboard state: one expected-beat queue per (instance, port).
    beat_t       q [12][$];
    int          raw_drop [3];
    int          ndel [3][4];
    int          last_cyc [3][4];
    int          last_lat [3][4];
    logic [15:0] last_pld [3][4];
    logic [3:0]  pv [3];
    logic [3:0]  pr [3];
    logic [17:0] pd [3][4];

    function automatic int snum_of(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int cmax_of(input int d);
        return (d == 2) ? 3 : 65535;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_accept(input int d, input logic [1:0] dst, input logic [15:0] pld);
        beat_t e;
        e.dst = dst; e.pld = pld; e.cyc = cyc;
        if (BCAST && dst == 2'b11) begin
            for (int p = 0; p < snum_of(d); p++) q[d*4+p].push_back(e);
        end else if (int'(dst) < snum_of(d)) begin
            q[d*4+int'(dst)].push_back(e);
        end else begin
            raw_drop[d]++;
        end
    endtask

    task automatic deliver(input int d, input int p);
        beat_t e;
        if (q[d*4+p].size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_beat dut%0d port%0d actual pld=%0h expected no beat", d, p, g_opld[d][p]);
        end else begin
            e = q[d*4+p].pop_front();
            chk($sformatf("beat_dut%0d_port%0d", d, p), {14'd0, g_odst[d][p], g_opld[d][p]}, {14'd0, e.dst, e.pld});
            last_pld[d][p] = g_opld[d][p];
            last_cyc[d][p] = cyc;
            last_lat[d][p] = cyc - e.cyc;
            ndel[d][p]++;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 12; i++) q[i].delete();
        for (int d = 0; d < 3; d++) raw_drop[d] = 0;
    endtask

    task automatic check_drop(input int d);
        int exp;
        exp = (raw_drop[d] > cmax_of(d)) ? cmax_of(d) : raw_drop[d];
        chk($sformatf("dropcnt_model_dut%0d", d), {16'd0, g_cnt[d]}, exp);
    endtask

    // Compare process: every handshake on every port, plus the hold-while-stalled rule.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) pv[d] = '0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (g_ivld[d] && g_irdy[d]) model_accept(d, g_idst[d], g_ipld[d]);
                for (int p = 0; p < snum_of(d); p++) begin
                    if (pv[d][p] && !pr[d][p])
                        chk($sformatf("hold_dut%0d_port%0d", d, p),
                            {13'd0, g_ovld[d][p], g_odst[d][p], g_opld[d][p]}, {13'd0, 1'b1, pd[d][p]});
                    if (g_ovld[d][p] && g_ordy[d][p]) deliver(d, p);
                    pv[d][p] = g_ovld[d][p];
                    pr[d][p] = g_ordy[d][p];
                    pd[d][p] = {g_odst[d][p], g_opld[d][p]};
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int sel, input logic [1:0] d, input logic [15:0] p);
        int n = 0;
        if (sel == 0) begin a_ivld = 1'b1; a_idst = d; a_ipld = p; end
        else          begin b_ivld = 1'b1; b_idst = d; b_ipld = p; end
        @(negedge clk);
        while (!((sel == 0) ? a_irdy : (b_irdy && c_irdy)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL send_timeout sel%0d actual rdy=0 expected rdy=1", sel);
        end
        @(posedge clk); #1;
        a_ivld = 1'b0; b_ivld = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; a_ivld = 1'b0; b_ivld = 1'b0;
        model_clear();
        idle(2);
        chk("rst_a_vld", a_ovld, 4'd0);
        chk("rst_b_vld", {b_ovld, c_ovld}, 6'd0);
        chk("rst_a_irdy", {a_irdy, b_irdy, c_irdy}, 3'd0);
        chk("rst_cnt_a", a_cnt, 0);
        chk("rst_cnt_bc", {b_cnt, c_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rel_irdy_low", a_irdy, 1'b0);
        idle(1);
        chk("rel_irdy_high", a_irdy, 1'b1);
    endtask

    int t0;
    int nd [4];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        cyc = 0; checks = 0; errors = 0;
        rst_n = 1'b0;
        a_ivld = 1'b0; a_idst = '0; a_ipld = '0; a_ordy = 4'hF;
        b_ivld = 1'b0; b_idst = '0; b_ipld = '0; b_ordy = 3'h7;
        for (int d = 0; d < 3; d++) begin
            raw_drop[d] = 0;
            pv[d] = '0;
            for (int p = 0; p < 4; p++) begin
                ndel[d][p] = 0; last_cyc[d][p] = 0; last_lat[d][p] = 0; last_pld[d][p] = '0;
            end
        end
        do_reset();

        // Unicast stream at full rate, 2-cycle latency
        t0 = cyc;
        for (int k = 0; k < 4; k++) send(0, 2'(k), 16'(16'h1111 * (k + 1)));
        chk("uni_rate", cyc - t0, 4);
        idle(4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("uni_pld_p%0d", k), last_pld[0][k], BCAST ? 32'h4444 : 32'h1111 * (k + 1));
            chk($sformatf("uni_lat_p%0d", k), last_lat[0][k], 2);
        end

        // Head-of-line blocking behind a stalled port 2
        a_ordy = 4'b1011;
        send(0, 2, 16'hA201); send(0, 2, 16'hA202); send(0, 2, 16'hA203); send(0, 0, 16'hA000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("hol_p0_quiet", a_ovld[0], 1'b0);
        end
        chk("hol_p2_head", a_opld[2], 16'hA201);
        idle(1);
        a_ordy = 4'hF;
        idle(8);
        chk("hol_p0_got", last_pld[0][0], 16'hA000);
        chk("hol_p2_last", last_pld[0][2], 16'hA203);
        chk("hol_order", last_cyc[0][0] > last_cyc[0][2], 1'b1);

        // Drops on SNUM=3 (Dst=3 illegal without broadcast), CW=16 vs CW=2 saturation
        nd[0] = ndel[1][0]; nd[1] = ndel[1][1];
        send(1, 3, 16'hD000); send(1, 1, 16'hD001); send(1, 3, 16'hD002); send(1, 1, 16'hD003);
        send(1, 3, 16'hD004); send(1, 3, 16'hD005); send(1, 1, 16'hD006); send(1, 3, 16'hD007);
        idle(5);
        chk("drop_cnt5", b_cnt, BCAST ? 0 : 5);
        chk("drop_sat3", c_cnt, BCAST ? 0 : 3);
        chk("drop_p1_beats", ndel[1][1] - nd[1], BCAST ? 8 : 3);
        chk("drop_p0_none", ndel[1][0] - nd[0], BCAST ? 5 : 0);
        send(1, 3, 16'hD008); send(1, 3, 16'hD009);
        idle(5);
        chk("drop_cnt7", b_cnt, BCAST ? 0 : 7);
        chk("drop_sat_hold", c_cnt, BCAST ? 0 : 3);
        check_drop(1); check_drop(2);

        // All-ones Dst on SNUM=4
        for (int k = 0; k < 4; k++) nd[k] = ndel[0][k];
        send(0, 3, 16'hF00F);
        idle(4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("ones_p%0d", k), ndel[0][k] - nd[k], (k == 3 || BCAST) ? 1 : 0);
        chk("ones_pld", last_pld[0][3], 16'hF00F);

`ifdef DCP_DISPATCH_BCAST_EN
        // Broadcast with ports accepting in order 3,0,2,1
        a_ordy = 4'h0;
        for (int k = 0; k < 3; k++) begin
            send(0, 2'(k), 16'(16'hC000 + k * 16)); send(0, 2'(k), 16'(16'hC001 + k * 16));
        end
        send(0, 3, 16'hBBBB); send(0, 1, 16'h1234);
        for (int k = 0; k < 4; k++) nd[k] = ndel[0][k];
        idle(3);
        a_ordy[3] = 1'b1; idle(1);
        a_ordy[0] = 1'b1; idle(1);
        a_ordy[2] = 1'b1; idle(1);
        a_ordy[1] = 1'b1; idle(10);
        chk("bc_p0", ndel[0][0] - nd[0], 3);
        chk("bc_p1", ndel[0][1] - nd[1], 4);
        chk("bc_p2", ndel[0][2] - nd[2], 3);
        chk("bc_p3", ndel[0][3] - nd[3], 1);
        chk("bc_next_after", last_pld[0][1], 16'h1234);
`endif

        // Reset with beats in flight (a partial broadcast when enabled)
        a_ordy = 4'h0; b_ordy = 3'h0;
        send(0, 0, 16'hE001); send(0, 0, 16'hE002); send(0, 3, 16'hE003); send(1, 3, 16'hE004);
        idle(3);
        chk("mid_p0_busy", a_ovld[0], 1'b1);
        do_reset();
        a_ordy = 4'hF; b_ordy = 3'h7;
        for (int k = 0; k < 4; k++) nd[k] = ndel[0][k];
        send(0, 1, 16'h5151);
        idle(4);
        chk("post_rst_p1", last_pld[0][1], 16'h5151);
        chk("post_rst_n", ndel[0][1] - nd[1], 1);
        chk("post_rst_quiet", (ndel[0][0] - nd[0]) + (ndel[0][3] - nd[3]), 0);
        check_drop(0); check_drop(1); check_drop(2);

        for (int d = 0; d < 3; d++)
            for (int p = 0; p < snum_of(d); p++)
                chk($sformatf("undelivered_dut%0d_port%0d", d, p), q[d*4+p].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
